psum_writeback: RTL and testbench

PSUM_WRITEBACK -- requirements
Module: psum_writeback

---
 rtl/eyeriss_pkg.sv | 16 +
 rtl/col_mask_next.sv | 25 ++
 rtl/psum_writeback.sv | 105 ++++++++++
 tb/tb_psum_writeback.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/eyeriss_pkg.sv
// rtl/eyeriss_pkg.sv - shared array constants and writeback state encoding
package eyeriss_pkg;

    localparam int NUM_COLS = 14;
    localparam int PSUM_W = 32;
    localparam int MEM_W = 16;
    localparam logic [15:0] RESULT_BASE = 16'h2000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE_LO = 2'd1,
        ST_WRITE_HI = 2'd2,
        ST_DONE     = 2'd3
    } writeback_state_t;

endpackage

// File: rtl/col_mask_next.sv
// rtl/col_mask_next.sv - lowest set mask bit strictly above col, or from lane 0 when from_start
module col_mask_next #(
    parameter int N = 14,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [CW-1:0] col,
    input  logic          from_start,
    output logic [CW-1:0] next_col,
    output logic          found
);

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        next_col = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (CW'(i) > col))) begin
                next_col = CW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_writeback.sv
// rtl/psum_writeback.sv - stores one masked row of psum lanes as lo/hi memory halfwords
module psum_writeback
    import eyeriss_pkg::*;
#(
    parameter int NUM_COLS = eyeriss_pkg::NUM_COLS,
    parameter int PSUM_W = eyeriss_pkg::PSUM_W,
    parameter int MEM_W = eyeriss_pkg::MEM_W,
    parameter logic [15:0] RESULT_BASE = eyeriss_pkg::RESULT_BASE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               store_req,
    input  logic [7:0]                         store_row,
    input  logic [NUM_COLS-1:0]                col_mask,
    input  logic [NUM_COLS-1:0][PSUM_W-1:0]    psum_out,
    output logic                               busy,
    output logic                               store_done,
    output logic                               mem_wr_en,
    output logic [15:0]                        mem_wr_addr,
    output logic [MEM_W-1:0]                   mem_wr_data,
    input  logic                               mem_wr_ready
);

    localparam int CW = $clog2(NUM_COLS);

    writeback_state_t state, state_nxt;

    logic [CW-1:0]                     col;
    logic [7:0]                        cap_row;
    logic [NUM_COLS-1:0]               cap_mask;
    logic [NUM_COLS-1:0][PSUM_W-1:0]   cap_psum;

    logic [CW-1:0] first_col, next_col;
    logic          first_found, next_found;
    logic          capture, accept;
    logic [PSUM_W-1:0] lane;
    logic [15:0]   row_off, col_off;

    col_mask_next #(.N(NUM_COLS)) u_first (
        .mask       (col_mask),
        .col        ({CW{1'b0}}),
        .from_start (1'b1),
        .next_col   (first_col),
        .found      (first_found)
    );

    col_mask_next #(.N(NUM_COLS)) u_next (
        .mask       (cap_mask),
        .col        (col),
        .from_start (1'b0),
        .next_col   (next_col),
        .found      (next_found)
    );

    assign capture = (state == ST_IDLE) && store_req;
    assign accept = mem_wr_en && mem_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            col <= '0;
            cap_row <= '0;
            cap_mask <= '0;
            cap_psum <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_row <= store_row;
                cap_mask <= col_mask;
                cap_psum <= psum_out;
                col <= first_col;
            end else if (state == ST_WRITE_HI && accept && next_found) begin
                col <= next_col;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (store_req) state_nxt = first_found ? ST_WRITE_LO : ST_DONE;
            ST_WRITE_LO: if (mem_wr_ready) state_nxt = ST_WRITE_HI;
            ST_WRITE_HI: if (mem_wr_ready) state_nxt = next_found ? ST_WRITE_LO : ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only, so they hold steady across stalls.
    always_comb begin
        busy = (state != ST_IDLE);
        store_done = (state == ST_DONE);
        mem_wr_en = (state == ST_WRITE_LO) || (state == ST_WRITE_HI);
        lane = cap_psum[col];
        row_off = 16'(cap_row) * 16'(2 * NUM_COLS);
        col_off = {15'(col), (state == ST_WRITE_HI)};
        mem_wr_addr = 16'h0;
        mem_wr_data = '0;
        if (mem_wr_en) begin
            mem_wr_addr = RESULT_BASE + row_off + col_off;
            mem_wr_data = (state == ST_WRITE_HI) ? lane[2*MEM_W-1:MEM_W] : lane[MEM_W-1:0];
        end
    end

endmodule

// File: tb/tb_psum_writeback.sv
// tb/tb_psum_writeback.sv - directed self-checking bench for psum_writeback
module tb_psum_writeback;

    logic               clk = 1'b0;
    logic               rst;
    logic               store_req;
    logic [7:0]         store_row;
    logic [13:0]        col_mask;
    logic [13:0][31:0]  psum;
    logic               mem_wr_ready;

    logic               busy, store_done, mem_wr_en;
    logic [15:0]        mem_wr_addr, mem_wr_data;
    logic               busy2, store_done2, mem_wr_en2;
    logic [15:0]        mem_wr_addr2, mem_wr_data2;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    psum_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .store_req    (store_req),
        .store_row    (store_row),
        .col_mask     (col_mask),
        .psum_out     (psum),
        .busy         (busy),
        .store_done   (store_done),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready)
    );

    psum_writeback #(.RESULT_BASE(16'hFFF0)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .store_req    (store_req),
        .store_row    (store_row),
        .col_mask     (col_mask),
        .psum_out     (psum),
        .busy         (busy2),
        .store_done   (store_done2),
        .mem_wr_en    (mem_wr_en2),
        .mem_wr_addr  (mem_wr_addr2),
        .mem_wr_data  (mem_wr_data2),
        .mem_wr_ready (mem_wr_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d,
                            input int stalls);
        for (int s = 0; s < stalls; s++) begin
            mem_wr_ready = 1'b0;
            check({tag, "_stall_en"}, 32'(mem_wr_en), 32'd1);
            check({tag, "_stall_addr"}, 32'(mem_wr_addr), 32'(a));
            check({tag, "_stall_data"}, 32'(mem_wr_data), 32'(d));
            tick();
        end
        mem_wr_ready = 1'b1;
        check({tag, "_en"}, 32'(mem_wr_en), 32'd1);
        check({tag, "_addr"}, 32'(mem_wr_addr), 32'(a));
        check({tag, "_data"}, 32'(mem_wr_data), 32'(d));
        tick();
    endtask

    initial begin
        rst = 1'b1;
        store_req = 1'b0;
        store_row = 8'd0;
        col_mask = '0;
        psum = '0;
        mem_wr_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(store_done), 32'd0);
        check("rst_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_wr_addr), 32'd0);
        check("rst_data", 32'(mem_wr_data), 32'd0);
        rst = 1'b0;
        tick();

        // Full row, no stalls: request cycle is cycle 1, done expected in cycle 30.
        for (int i = 0; i < 14; i++) psum[i] = 32'hA000_0000 + 32'(i);
        store_req = 1'b1;
        col_mask = 14'h3FFF;
        store_row = 8'd0;
        check("full_idle_busy", 32'(busy), 32'd0);
        tick();
        store_req = 1'b0;
        psum = '1;
        for (int k = 0; k < 28; k++) begin
            check("full_en", 32'(mem_wr_en), 32'd1);
            check("full_addr", 32'(mem_wr_addr), 32'h2000 + 32'(k));
            check("full_data", 32'(mem_wr_data), (k % 2 == 0) ? 32'(k / 2) : 32'hA000);
            check("full_nodone", 32'(store_done), 32'd0);
            tick();
        end
        check("full_done_c30", 32'(store_done), 32'd1);
        check("full_done_en", 32'(mem_wr_en), 32'd0);
        tick();
        check("full_done_pulse", 32'(store_done), 32'd0);
        check("full_idle", 32'(busy), 32'd0);

        // Sparse lanes 0, 2, 13 on row 2 with three stall cycles per write.
        for (int i = 0; i < 14; i++) psum[i] = {16'h5A00 + 16'(i), 16'h0100 + 16'(i)};
        store_req = 1'b1;
        col_mask = 14'b10_0000_0000_0101;
        store_row = 8'd2;
        mem_wr_ready = 1'b0;
        tick();
        store_req = 1'b0;
        psum = '0;
        do_write("sp_l0_lo", 16'h2038, 16'h0100, 3);
        do_write("sp_l0_hi", 16'h2039, 16'h5A00, 3);
        do_write("sp_l2_lo", 16'h203C, 16'h0102, 3);
        do_write("sp_l2_hi", 16'h203D, 16'h5A02, 3);
        do_write("sp_l13_lo", 16'h2052, 16'h010D, 3);
        do_write("sp_l13_hi", 16'h2053, 16'h5A0D, 3);
        check("sp_done", 32'(store_done), 32'd1);
        tick();
        check("sp_idle", 32'(busy), 32'd0);

        // Zero mask, request held through DONE: ignored in DONE, retaken in the next IDLE.
        store_req = 1'b1;
        col_mask = '0;
        store_row = 8'd5;
        check("zm_c1_en", 32'(mem_wr_en), 32'd0);
        tick();
        check("zm_c2_done", 32'(store_done), 32'd1);
        check("zm_c2_en", 32'(mem_wr_en), 32'd0);
        tick();
        check("zm_c3_busy", 32'(busy), 32'd0);
        check("zm_c3_done", 32'(store_done), 32'd0);
        tick();
        store_req = 1'b0;
        check("zm_c4_redone", 32'(store_done), 32'd1);
        tick();
        check("zm_c5_idle", 32'(busy), 32'd0);

        // Reset during WRITE_HI of lane 3 on row 1.
        for (int i = 0; i < 14; i++) psum[i] = 32'h0000_1110 + 32'(i);
        store_req = 1'b1;
        col_mask = 14'h3FFF;
        store_row = 8'd1;
        tick();
        store_req = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("rm_hi3_en", 32'(mem_wr_en), 32'd1);
        check("rm_hi3_addr", 32'(mem_wr_addr), 32'h2023);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_en_low", 32'(mem_wr_en), 32'd0);
        check("rm_busy_low", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("rm_no_done", 32'(store_done), 32'd0);
            tick();
        end
        for (int i = 0; i < 14; i++) psum[i] = 32'h7700_0000 + 32'(i);
        store_req = 1'b1;
        col_mask = 14'h3FFF;
        store_row = 8'd0;
        tick();
        store_req = 1'b0;
        check("rm_restart_addr", 32'(mem_wr_addr), 32'h2000);
        check("rm_restart_data", 32'(mem_wr_data), 32'h0000);
        tick();
        check("rm_restart_hi", 32'(mem_wr_data), 32'h7700);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Row 255 lane 0 with a second request while busy; wrapping instance uses base 0xFFF0.
        psum[0] = 32'h1234_5678;
        store_req = 1'b1;
        col_mask = 14'h0001;
        store_row = 8'd255;
        tick();
        store_row = 8'd7;
        col_mask = 14'h3FFF;
        check("bw_lo_addr", 32'(mem_wr_addr), 32'h3BE4);
        check("bw_lo_addr_wrap", 32'(mem_wr_addr2), 32'h1BD4);
        check("bw_lo_data", 32'(mem_wr_data2), 32'h5678);
        tick();
        check("bw_hi_addr_wrap", 32'(mem_wr_addr2), 32'h1BD5);
        check("bw_hi_data", 32'(mem_wr_data2), 32'h1234);
        tick();
        store_req = 1'b0;
        check("bw_done", 32'(store_done), 32'd1);
        tick();
        check("bw_single_done", 32'(store_done), 32'd0);
        check("bw_not_queued", 32'(busy), 32'd0);
        tick();
        check("bw_still_idle", 32'(busy), 32'd0);
        check("bw_no_write", 32'(mem_wr_en), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
